// File: rtl/alu_issue_pkg.sv
// +--------------------------------------------------------------------------+
// | alu_issue_pkg: ALU control encoding, MIPS opcode/funct codes, bundle.    |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

package alu_issue_pkg;

  localparam int c_idx_add  = 11;
  localparam int c_idx_sub  = 10;
  localparam int c_idx_slt  = 9;
  localparam int c_idx_sltu = 8;
  localparam int c_idx_and  = 7;
  localparam int c_idx_nor  = 6;
  localparam int c_idx_or   = 5;
  localparam int c_idx_xor  = 4;
  localparam int c_idx_sll  = 3;
  localparam int c_idx_srl  = 2;
  localparam int c_idx_sra  = 1;
  localparam int c_idx_lui  = 0;

  localparam logic [11:0] c_alu_add  = 12'b1 << c_idx_add;
  localparam logic [11:0] c_alu_sub  = 12'b1 << c_idx_sub;
  localparam logic [11:0] c_alu_slt  = 12'b1 << c_idx_slt;
  localparam logic [11:0] c_alu_sltu = 12'b1 << c_idx_sltu;
  localparam logic [11:0] c_alu_and  = 12'b1 << c_idx_and;
  localparam logic [11:0] c_alu_nor  = 12'b1 << c_idx_nor;
  localparam logic [11:0] c_alu_or   = 12'b1 << c_idx_or;
  localparam logic [11:0] c_alu_xor  = 12'b1 << c_idx_xor;
  localparam logic [11:0] c_alu_sll  = 12'b1 << c_idx_sll;
  localparam logic [11:0] c_alu_srl  = 12'b1 << c_idx_srl;
  localparam logic [11:0] c_alu_sra  = 12'b1 << c_idx_sra;
  localparam logic [11:0] c_alu_lui  = 12'b1 << c_idx_lui;

  localparam logic [5:0] c_op_special = 6'h00;
  localparam logic [5:0] c_op_addi    = 6'h08;
  localparam logic [5:0] c_op_addiu   = 6'h09;
  localparam logic [5:0] c_op_slti    = 6'h0A;
  localparam logic [5:0] c_op_sltiu   = 6'h0B;
  localparam logic [5:0] c_op_andi    = 6'h0C;
  localparam logic [5:0] c_op_ori     = 6'h0D;
  localparam logic [5:0] c_op_xori    = 6'h0E;
  localparam logic [5:0] c_op_lui     = 6'h0F;

  localparam logic [5:0] c_fn_sll  = 6'h00;
  localparam logic [5:0] c_fn_srl  = 6'h02;
  localparam logic [5:0] c_fn_sra  = 6'h03;
  localparam logic [5:0] c_fn_sllv = 6'h04;
  localparam logic [5:0] c_fn_srlv = 6'h06;
  localparam logic [5:0] c_fn_srav = 6'h07;
  localparam logic [5:0] c_fn_add  = 6'h20;
  localparam logic [5:0] c_fn_addu = 6'h21;
  localparam logic [5:0] c_fn_sub  = 6'h22;
  localparam logic [5:0] c_fn_subu = 6'h23;
  localparam logic [5:0] c_fn_and  = 6'h24;
  localparam logic [5:0] c_fn_or   = 6'h25;
  localparam logic [5:0] c_fn_xor  = 6'h26;
  localparam logic [5:0] c_fn_nor  = 6'h27;
  localparam logic [5:0] c_fn_slt  = 6'h2A;
  localparam logic [5:0] c_fn_sltu = 6'h2B;

  typedef struct packed {
    logic [11:0] alu_control;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [4:0]  dest;
    logic        wen;
    logic        illegal;
    logic [31:0] pc;
  } issue_bundle_t;

  function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

  function automatic logic [31:0] zero_ext16(input logic [15:0] imm);
    return {16'd0, imm};
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_issue_decode.sv
// +--------------------------------------------------------------------------+
// | alu_issue_decode: combinational decode of ALU-class MIPS instructions.   |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module alu_issue_decode
  import alu_issue_pkg::*;
#(
  parameter int ZERO_DEST_SUPPRESS = 1
) (
  input  logic [31:0] inst,
  input  logic [31:0] rs_value,
  input  logic [31:0] rt_value,
  output logic [11:0] alu_control,
  output logic [31:0] src1,
  output logic [31:0] src2,
  output logic [4:0]  dest,
  output logic        wen,
  output logic        illegal
);

  logic [5:0]  w_op;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [4:0]  w_sa;
  logic [5:0]  w_funct;
  logic [15:0] w_imm;
  logic        w_legal;
  logic        w_unused_rs_field;

  assign w_op    = inst[31:26];
  assign w_rt    = inst[20:16];
  assign w_rd    = inst[15:11];
  assign w_sa    = inst[10:6];
  assign w_funct = inst[5:0];
  assign w_imm   = inst[15:0];

  // The rs index was already consumed by the regfile read upstream.
  assign w_unused_rs_field = ^inst[25:21];

  always_comb begin
    alu_control = '0;
    src1        = '0;
    src2        = '0;
    dest        = '0;
    w_legal     = 1'b0;
    case (w_op)
      c_op_special: begin
        w_legal = 1'b1;
        dest    = w_rd;
        src1    = rs_value;
        src2    = rt_value;
        case (w_funct)
          c_fn_add,  c_fn_addu: alu_control = c_alu_add;
          c_fn_sub,  c_fn_subu: alu_control = c_alu_sub;
          c_fn_slt:             alu_control = c_alu_slt;
          c_fn_sltu:            alu_control = c_alu_sltu;
          c_fn_and:             alu_control = c_alu_and;
          c_fn_or:              alu_control = c_alu_or;
          c_fn_xor:             alu_control = c_alu_xor;
          c_fn_nor:             alu_control = c_alu_nor;
          c_fn_sll,  c_fn_sllv: alu_control = c_alu_sll;
          c_fn_srl,  c_fn_srlv: alu_control = c_alu_srl;
          c_fn_sra,  c_fn_srav: alu_control = c_alu_sra;
          default:              w_legal     = 1'b0;
        endcase
        // Immediate shifts take the shift amount from the sa field.
        if (w_funct == c_fn_sll || w_funct == c_fn_srl || w_funct == c_fn_sra)
          src1 = {27'd0, w_sa};
      end
      c_op_addi, c_op_addiu, c_op_slti, c_op_sltiu: begin
        w_legal     = 1'b1;
        dest        = w_rt;
        src1        = rs_value;
        src2        = sign_ext16(w_imm);
        alu_control = (w_op == c_op_slti)  ? c_alu_slt  :
                      (w_op == c_op_sltiu) ? c_alu_sltu : c_alu_add;
      end
      c_op_andi, c_op_ori, c_op_xori: begin
        w_legal     = 1'b1;
        dest        = w_rt;
        src1        = rs_value;
        src2        = zero_ext16(w_imm);
        alu_control = (w_op == c_op_andi) ? c_alu_and :
                      (w_op == c_op_ori)  ? c_alu_or  : c_alu_xor;
      end
      c_op_lui: begin
        w_legal     = 1'b1;
        dest        = w_rt;
        src2        = zero_ext16(w_imm);
        alu_control = c_alu_lui;
      end
      default: w_legal = 1'b0;
    endcase
    if (!w_legal) begin
      alu_control = '0;
      src1        = '0;
      src2        = '0;
      dest        = '0;
    end
  end

  assign illegal = ~w_legal;
  assign wen     = w_legal & ~((ZERO_DEST_SUPPRESS != 0) && (dest == 5'd0));

endmodule

`default_nettype wire

// File: rtl/alu_issue_stage.sv
// +--------------------------------------------------------------------------+
// | alu_issue_stage: ID/EXE register with valid/ready handshake for the ALU. |
// | Optional one-entry skid buffer: define ALU_ISSUE_SKID_EN.                |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module alu_issue_stage
  import alu_issue_pkg::*;
#(
  parameter int ZERO_DEST_SUPPRESS = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs_value,
  input  logic [31:0] in_rt_value,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] out_alu_control,
  output logic [31:0] out_alu_src1,
  output logic [31:0] out_alu_src2,
  output logic [4:0]  out_dest,
  output logic        out_wen,
  output logic        out_illegal,
  output logic [31:0] out_pc
);

  logic [11:0]   w_ctl;
  logic [31:0]   w_src1;
  logic [31:0]   w_src2;
  logic [4:0]    w_dest;
  logic          w_wen;
  logic          w_illegal;
  issue_bundle_t w_dec;
  issue_bundle_t r_out;
  logic          r_out_valid;
  logic          w_accept;

  alu_issue_decode #(
    .ZERO_DEST_SUPPRESS(ZERO_DEST_SUPPRESS)
  ) u_decode (
    .inst        (in_inst),
    .rs_value    (in_rs_value),
    .rt_value    (in_rt_value),
    .alu_control (w_ctl),
    .src1        (w_src1),
    .src2        (w_src2),
    .dest        (w_dest),
    .wen         (w_wen),
    .illegal     (w_illegal)
  );

  assign w_dec = '{alu_control: w_ctl, src1: w_src1, src2: w_src2, dest: w_dest,
                   wen: w_wen, illegal: w_illegal, pc: in_pc};

`ifdef ALU_ISSUE_SKID_EN
  issue_bundle_t r_skid;
  logic          r_skid_valid;

  // Registered-only ready: out_ready never reaches in_ready combinationally.
  assign in_ready = ~r_skid_valid;
  assign w_accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_out        <= '0;
      r_out_valid  <= 1'b0;
      r_skid       <= '0;
      r_skid_valid <= 1'b0;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (!r_out_valid || out_ready) begin
      if (r_skid_valid) begin
        r_out        <= r_skid;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_out       <= w_dec;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid       <= w_dec;
      r_skid_valid <= 1'b1;
    end
  end
`else
  assign in_ready = ~r_out_valid | out_ready;
  assign w_accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out       <= w_dec;
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end
`endif

  assign out_valid       = r_out_valid;
  assign out_alu_control = r_out.alu_control;
  assign out_alu_src1    = r_out.src1;
  assign out_alu_src2    = r_out.src2;
  assign out_dest        = r_out.dest;
  assign out_wen         = r_out.wen;
  assign out_illegal     = r_out.illegal;
  assign out_pc          = r_out.pc;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
// +--------------------------------------------------------------------------+
// | tb_alu_issue_stage: directed scoreboard bench for alu_issue_stage.       |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_alu_issue_stage;

`ifdef ALU_ISSUE_SKID_EN
  localparam bit c_skid = 1'b1;
`else
  localparam bit c_skid = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic [31:0] in_rs_value;
  logic [31:0] in_rt_value;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_alu_control;
  logic [31:0] out_alu_src1;
  logic [31:0] out_alu_src2;
  logic [4:0]  out_dest;
  logic        out_wen;
  logic        out_illegal;
  logic [31:0] out_pc;

  alu_issue_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_inst         (in_inst),
    .in_pc           (in_pc),
    .in_rs_value     (in_rs_value),
    .in_rt_value     (in_rt_value),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_alu_control (out_alu_control),
    .out_alu_src1    (out_alu_src1),
    .out_alu_src2    (out_alu_src2),
    .out_dest        (out_dest),
    .out_wen         (out_wen),
    .out_illegal     (out_illegal),
    .out_pc          (out_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int          id;
    logic [11:0] ctl;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [4:0]  dest;
    logic        chk_dest;
    logic        wen;
    logic        ill;
    logic [31:0] pc;
  } exp_t;

  exp_t q[$];
  exp_t pend_exp;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input int id, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s[%0d] observed=0x%08h expected=0x%08h", tag, id, obs, exp);
    end
  endtask

  task automatic send(input int id, input logic [31:0] inst, input logic [31:0] pc,
                      input logic [31:0] rs, input logic [31:0] rt,
                      input logic [11:0] ctl, input logic [31:0] s1, input logic [31:0] s2,
                      input logic [4:0] dst, input logic chkd, input logic wen, input logic ill);
    in_valid    = 1'b1;
    in_inst     = inst;
    in_pc       = pc;
    in_rs_value = rs;
    in_rt_value = rt;
    pend_exp    = '{id: id, ctl: ctl, s1: s1, s2: s2, dest: dst, chk_dest: chkd,
                    wen: wen, ill: ill, pc: pc};
  endtask

  // One clock: score the handshake just before the rising edge, return at the falling edge.
  task automatic tick();
    logic acc;
    logic drn;
    logic fl;
    exp_t e;
    #1;
    acc = in_valid & in_ready;
    drn = out_valid & out_ready;
    fl  = flush;
    if (fl) begin
      q.delete();
    end else begin
      if (drn) begin
        n_cmp++;
        assert (q.size() != 0) else begin
          n_err++;
          $error("FAIL spurious_output observed=out_valid pc=0x%08h expected=no_output", out_pc);
        end
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("control", e.id, 32'(out_alu_control), 32'(e.ctl));
          chk("src1", e.id, out_alu_src1, e.s1);
          chk("src2", e.id, out_alu_src2, e.s2);
          if (e.chk_dest) chk("dest", e.id, 32'(out_dest), 32'(e.dest));
          chk("wen", e.id, 32'(out_wen), 32'(e.wen));
          chk("illegal", e.id, 32'(out_illegal), 32'(e.ill));
          chk("pc", e.id, out_pc, e.pc);
        end
      end
      if (acc) q.push_back(pend_exp);
    end
    @(posedge clk);
    @(negedge clk);
    if (acc || fl) in_valid = 1'b0;
  endtask

  task automatic drain(input int bound);
    out_ready = 1'b1;
    for (int i = 0; i < bound && (q.size() != 0 || in_valid); i++) tick();
    n_cmp++;
    assert (q.size() == 0 && !in_valid) else begin
      n_err++;
      $error("FAIL drain_timeout observed=%0d_left expected=0_left", q.size());
    end
  endtask

  initial begin
    resetn      = 1'b0;
    flush       = 1'b0;
    in_valid    = 1'b0;
    in_inst     = '0;
    in_pc       = '0;
    in_rs_value = '0;
    in_rt_value = '0;
    out_ready   = 1'b0;
    pend_exp    = '0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_out_valid", 0, 32'(out_valid), 32'd0);
    chk("rst_control", 0, 32'(out_alu_control), 32'd0);
    chk("rst_src1", 0, out_alu_src1, 32'd0);
    chk("rst_pc", 0, out_pc, 32'd0);
    chk("rst_wen", 0, 32'(out_wen), 32'd0);
    resetn = 1'b1;
    #1;
    chk("rst_in_ready", 0, 32'(in_ready), 32'd1);
    @(negedge clk);

    // Streaming decode checks with the sink always ready
    out_ready = 1'b1;
    send(1, 32'h00221821, 32'h100, 32'd5, 32'd7, 12'h800, 32'd5, 32'd7, 5'd3, 1'b1, 1'b1, 1'b0);
    tick();
    chk("latency_out_valid", 1, 32'(out_valid), 32'd1);
    send(2, 32'h000520C3, 32'h104, 32'h0, 32'h80000000, 12'h002, 32'd3, 32'h80000000, 5'd4, 1'b1, 1'b1, 1'b0);
    tick();
    send(3, 32'h2402FFFF, 32'h108, 32'h10, 32'h0, 12'h800, 32'h10, 32'hFFFFFFFF, 5'd2, 1'b1, 1'b1, 1'b0);
    tick();
    send(4, 32'h3002FFFF, 32'h10C, 32'h55, 32'h0, 12'h080, 32'h55, 32'h0000FFFF, 5'd2, 1'b1, 1'b1, 1'b0);
    tick();
    send(5, 32'h3C011234, 32'h110, 32'hDEADBEEF, 32'h0, 12'h001, 32'h0, 32'h00001234, 5'd1, 1'b1, 1'b1, 1'b0);
    tick();
    send(6, 32'hFC000000, 32'h114, 32'h1, 32'h2, 12'h000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1);
    tick();
    send(7, 32'h00220021, 32'h118, 32'h9, 32'hA, 12'h800, 32'h9, 32'hA, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    send(8, 32'h00A22004, 32'h11C, 32'h4, 32'h3, 12'h008, 32'h4, 32'h3, 5'd4, 1'b1, 1'b1, 1'b0);
    tick();
    send(9, 32'h0022182A, 32'h120, 32'h1, 32'h2, 12'h200, 32'h1, 32'h2, 5'd3, 1'b1, 1'b1, 1'b0);
    tick();
    send(10, 32'h00221822, 32'h124, 32'h8, 32'h3, 12'h400, 32'h8, 32'h3, 5'd3, 1'b1, 1'b1, 1'b0);
    tick();
    drain(10);

    // Backpressure: two back-to-back inputs against a 3-cycle stall
    out_ready = 1'b0;
    send(11, 32'h00221821, 32'h200, 32'h11, 32'h22, 12'h800, 32'h11, 32'h22, 5'd3, 1'b1, 1'b1, 1'b0);
    tick();
    chk("bp_out_valid", 11, 32'(out_valid), 32'd1);
    send(12, 32'h00221822, 32'h204, 32'h33, 32'h44, 12'h400, 32'h33, 32'h44, 5'd3, 1'b1, 1'b1, 1'b0);
    #1;
    chk("bp_in_ready_2nd", 12, 32'(in_ready), 32'(c_skid));
    @(negedge clk);
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready_stall", 12, 32'(in_ready), 32'd0);
      chk("bp_hold_valid", 11, 32'(out_valid), 32'd1);
      chk("bp_hold_pc", 11, out_pc, 32'h200);
      chk("bp_hold_src1", 11, out_alu_src1, 32'h11);
      @(negedge clk);
      tick();
    end
    drain(20);

    // Flush while stalled with a full stage
    out_ready = 1'b0;
    send(13, 32'h00221821, 32'h300, 32'h1, 32'h1, 12'h800, 32'h1, 32'h1, 5'd3, 1'b1, 1'b1, 1'b0);
    tick();
    send(14, 32'h00221821, 32'h304, 32'h2, 32'h2, 12'h800, 32'h2, 32'h2, 5'd3, 1'b1, 1'b1, 1'b0);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("flush_out_valid", 14, 32'(out_valid), 32'd0);
    chk("flush_in_ready", 14, 32'(in_ready), 32'd1);
    @(negedge clk);
    out_ready = 1'b1;
    tick();
    tick();
    chk("flush_stays_empty", 14, 32'(out_valid), 32'd0);

    // Flush drops a same-cycle input
    send(15, 32'h00221821, 32'h400, 32'h3, 32'h3, 12'h800, 32'h3, 32'h3, 5'd3, 1'b1, 1'b1, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_drop_valid", 15, 32'(out_valid), 32'd0);
    tick();
    chk("flush_drop_stays", 15, 32'(out_valid), 32'd0);

    // Normal flow resumes after flush
    send(16, 32'h00221821, 32'h500, 32'h6, 32'h7, 12'h800, 32'h6, 32'h7, 5'd3, 1'b1, 1'b1, 1'b0);
    tick();
    drain(10);

    // Asynchronous reset in the middle of a stall
    out_ready = 1'b0;
    send(17, 32'h3C011234, 32'h600, 32'h0, 32'h0, 12'h001, 32'h0, 32'h1234, 5'd1, 1'b1, 1'b1, 1'b0);
    tick();
    chk("mid_stall_valid", 17, 32'(out_valid), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_rst_valid", 17, 32'(out_valid), 32'd0);
    chk("async_rst_control", 17, 32'(out_alu_control), 32'd0);
    chk("async_rst_src2", 17, out_alu_src2, 32'd0);
    chk("async_rst_dest", 17, 32'(out_dest), 32'd0);
    chk("async_rst_pc", 17, out_pc, 32'd0);
    q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("post_rst_in_ready", 17, 32'(in_ready), 32'd1);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
